ripple_sampler: RTL and testbench

RIPPLE_SAMPLER -- requirements
Module: ripple_sampler

---
 rtl/ripple_sampler.sv | 151 +++++++++++++++
 tb/tb_ripple_sampler.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ripple_sampler.sv
// ripple_sampler: synchronizes an asynchronous 4-bit ripple counter, waits for
// the sampled value to settle, extends it with a wrap count and hands a captured
// {ext, settled} snapshot to a consumer with a valid/ready style handshake.
module ripple_sampler #(
   parameter int unsigned STABLE_CYCLES = 2,
   parameter int unsigned EXT_W         = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [3:0]         cnt_in,
   input  logic               req,
   input  logic               out_ready,
   output logic               out_valid,
   output logic [EXT_W+3:0]   out_count,
   output logic               wrap_pulse,
   output logic               req_drop,
   output logic               ext_ovf
);

   localparam int unsigned CNT_W = $clog2(STABLE_CYCLES);
   localparam int unsigned OUT_W = EXT_W + 4;
   localparam logic [CNT_W-1:0] STAB_MAX = CNT_W'(STABLE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      WAIT_STABLE = 2'd1,
      VALID       = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [3:0]         sync1_q, sync1_d;
   logic [3:0]         sync2_q, sync2_d;
   logic [CNT_W-1:0]   stab_cnt_q, stab_cnt_d;
   logic [3:0]         settled_q, settled_d;
   logic [EXT_W-1:0]   ext_q, ext_d;
   logic               ext_ovf_q, ext_ovf_d;
   logic               wrap_pulse_q, wrap_pulse_d;
   logic [OUT_W-1:0]   out_count_q, out_count_d;
   logic               out_valid_q, out_valid_d;
   logic               req_drop_q, req_drop_d;
   logic               stable_c;

   // The counter register reflects how long sync2 has held its current value,
   // so a freshly arrived value always starts from zero and cannot look stable.
   assign stable_c = (stab_cnt_q == STAB_MAX);

   // Synchronizer, stability tracking, settled value and wrap extension.
   always_comb begin
      sync1_d      = cnt_in;
      sync2_d      = sync1_q;
      stab_cnt_d   = stab_cnt_q;
      settled_d    = settled_q;
      ext_d        = ext_q;
      ext_ovf_d    = ext_ovf_q;
      wrap_pulse_d = 1'b0;

      if (sync1_q != sync2_q) begin
         stab_cnt_d = '0;
      end else if (stab_cnt_q != STAB_MAX) begin
         stab_cnt_d = stab_cnt_q + CNT_W'(1);
      end

      if (stable_c) begin
         settled_d = sync2_q;
         // An up-only counter can only appear to decrease by wrapping.
         if (sync2_q < settled_q) begin
            wrap_pulse_d = 1'b1;
            ext_d        = ext_q + EXT_W'(1);
            if (ext_q == {EXT_W{1'b1}}) begin
               ext_ovf_d = 1'b1;
            end
         end
      end
   end

   // Capture FSM: next state, snapshot register and dropped-request pulse.
   always_comb begin
      state_d     = state_q;
      out_count_d = out_count_q;
      req_drop_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (req) begin
               state_d = WAIT_STABLE;
            end
         end
         WAIT_STABLE: begin
            req_drop_d = req;
            if (stable_c) begin
               out_count_d = {ext_d, settled_d};
               state_d     = VALID;
            end
         end
         VALID: begin
            req_drop_d = req;
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      out_valid_d = (state_d == VALID);
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q      <= '0;
         sync2_q      <= '0;
         stab_cnt_q   <= '0;
         settled_q    <= '0;
         ext_q        <= '0;
         ext_ovf_q    <= 1'b0;
         wrap_pulse_q <= 1'b0;
         out_count_q  <= '0;
         out_valid_q  <= 1'b0;
         req_drop_q   <= 1'b0;
      end else begin
         sync1_q      <= sync1_d;
         sync2_q      <= sync2_d;
         stab_cnt_q   <= stab_cnt_d;
         settled_q    <= settled_d;
         ext_q        <= ext_d;
         ext_ovf_q    <= ext_ovf_d;
         wrap_pulse_q <= wrap_pulse_d;
         out_count_q  <= out_count_d;
         out_valid_q  <= out_valid_d;
         req_drop_q   <= req_drop_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_count  = out_count_q;
   assign wrap_pulse = wrap_pulse_q;
   assign req_drop   = req_drop_q;
   assign ext_ovf    = ext_ovf_q;

endmodule

// File: tb/tb_ripple_sampler.sv
// Testbench for ripple_sampler: table of settle/capture vectors plus directed
// sequences for glitches, wraps, ext overflow, handshake and reset corners.
module tb_ripple_sampler;

   localparam int unsigned STABLE_CYCLES = 2;
   localparam int unsigned EXT_W         = 4;
   localparam int unsigned OUT_W         = EXT_W + 4;

   logic             clk = 1'b0;
   logic             rst;
   logic [3:0]       cnt_in;
   logic             req;
   logic             out_ready;
   logic             out_valid;
   logic [OUT_W-1:0] out_count;
   logic             wrap_pulse;
   logic             req_drop;
   logic             ext_ovf;

   int errors = 0;
   int checks = 0;
   int wraps  = 0;
   int drops  = 0;

   logic [OUT_W-1:0] sb_q[$];

   typedef struct {
      logic [3:0]       cnt;
      logic [OUT_W-1:0] exp_count;
      int               exp_wraps;
   } vec_t;

   vec_t vecs[7];

   ripple_sampler #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .EXT_W         (EXT_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .cnt_in     (cnt_in),
      .req        (req),
      .out_ready  (out_ready),
      .out_valid  (out_valid),
      .out_count  (out_count),
      .wrap_pulse (wrap_pulse),
      .req_drop   (req_drop),
      .ext_ovf    (ext_ovf)
   );

   always #5 clk = ~clk;

   // Advance one cycle; sample on the falling edge and count one-cycle pulses.
   task automatic tick();
      @(negedge clk);
      if (wrap_pulse) wraps++;
      if (req_drop)   drops++;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req = 1'b0;
      out_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic hold(input logic [3:0] v, input int n);
      cnt_in = v;
      repeat (n) tick();
   endtask

   task automatic pulse_req(input logic [OUT_W-1:0] exp);
      sb_q.push_back(exp);
      req = 1'b1;
      tick();
      req = 1'b0;
   endtask

   task automatic wait_valid(input string name, input int budget, output int lat);
      lat = 0;
      while (!out_valid && lat < budget) begin
         tick();
         lat++;
      end
      check({name, "_valid"}, 32'(out_valid), 32'd1);
   endtask

   // Compare the captured value against the scoreboard, then release it.
   task automatic consume(input string name);
      logic [OUT_W-1:0] exp;
      exp = '0;
      if (sb_q.size() > 0) exp = sb_q.pop_front();
      check(name, 32'(out_count), 32'(exp));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({name, "_release"}, 32'(out_valid), 32'd0);
   endtask

   task automatic capture(input string name, input logic [OUT_W-1:0] exp);
      int lat;
      pulse_req(exp);
      wait_valid(name, 20, lat);
      consume(name);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int w0;
      int d0;
      logic [OUT_W-1:0] held;

      vecs[0] = '{4'd5,  8'h05, 0};
      vecs[1] = '{4'd9,  8'h09, 0};
      vecs[2] = '{4'd3,  8'h13, 1};
      vecs[3] = '{4'd14, 8'h1E, 0};
      vecs[4] = '{4'd15, 8'h1F, 0};
      vecs[5] = '{4'd0,  8'h20, 1};
      vecs[6] = '{4'd1,  8'h21, 0};

      cnt_in = 4'd0;
      req = 1'b0;
      out_ready = 1'b0;
      rst = 1'b1;
      tick();
      tick();
      check("rst_out_valid",  32'(out_valid),  32'd0);
      check("rst_out_count",  32'(out_count),  32'd0);
      check("rst_wrap_pulse", 32'(wrap_pulse), 32'd0);
      check("rst_req_drop",   32'(req_drop),   32'd0);
      check("rst_ext_ovf",    32'(ext_ovf),    32'd0);
      rst = 1'b0;

      // Settle: value held, capture latency bounded, output held until ready.
      hold(4'd5, 6);
      pulse_req(8'h05);
      wait_valid("settle", 20, lat);
      check("settle_latency_ok", 32'(lat + 1 <= 2 + STABLE_CYCLES), 32'd1);
      repeat (3) tick();
      check("settle_hold_valid", 32'(out_valid), 32'd1);
      check("settle_hold_count", 32'(out_count), 32'h05);
      consume("settle");

      // Table of settled values with expected captures and wrap counts.
      do_reset();
      for (int i = 0; i < 7; i++) begin
         w0 = wraps;
         hold(vecs[i].cnt, 6);
         capture($sformatf("vec%0d", i), vecs[i].exp_count);
         check($sformatf("vec%0d_wraps", i), 32'(wraps - w0), 32'(vecs[i].exp_wraps));
      end

      // Glitch: single-cycle transients never settle and never wrap.
      do_reset();
      hold(4'd7, 6);
      w0 = wraps;
      hold(4'd0, 1);
      hold(4'd7, 1);
      hold(4'd0, 1);
      hold(4'd8, 6);
      check("glitch_wraps", 32'(wraps - w0), 32'd0);
      capture("glitch", 8'h08);

      // Wrap: 14 -> 15 -> 0 gives exactly one wrap.
      do_reset();
      w0 = wraps;
      hold(4'd14, 6);
      hold(4'd15, 6);
      hold(4'd0, 6);
      check("wrap_count", 32'(wraps - w0), 32'd1);
      capture("wrap", 8'h10);

      // Handshake: dropped requests and a held output.
      do_reset();
      hold(4'd6, 6);
      d0 = drops;
      sb_q.push_back(8'h06);
      req = 1'b1;
      tick();
      tick();
      req = 1'b0;
      tick();
      req = 1'b1;
      tick();
      req = 1'b0;
      tick();
      check("hs_drops", 32'(drops - d0), 32'd2);
      held = out_count;
      for (int i = 0; i < 10; i++) begin
         tick();
         check($sformatf("hs_hold%0d", i), 32'(out_count), 32'h06);
      end
      check("hs_valid", 32'(out_valid), 32'd1);
      consume("hs");

      // Ext overflow: sixteen wraps roll ext back to zero and set the flag.
      do_reset();
      w0 = wraps;
      for (int i = 0; i < 16; i++) begin
         hold(4'd8, 6);
         hold(4'd0, 6);
         if (i == 14) begin
            check("ovf_before", 32'(ext_ovf), 32'd0);
            capture("ovf_ext15", 8'hF0);
         end
      end
      check("ovf_wraps", 32'(wraps - w0), 32'd16);
      check("ovf_set", 32'(ext_ovf), 32'd1);
      capture("ovf_ext0", 8'h00);
      hold(4'd8, 6);
      hold(4'd0, 6);
      check("ovf_sticky", 32'(ext_ovf), 32'd1);
      capture("ovf_ext1", 8'h10);

      // Reset while VALID discards the capture and clears ext.
      hold(4'd3, 6);
      pulse_req(8'h13);
      wait_valid("midop", 20, lat);
      check("midop_count", 32'(out_count), 32'h13);
      void'(sb_q.pop_front());
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midop_rst_valid", 32'(out_valid), 32'd0);
      check("midop_rst_count", 32'(out_count), 32'd0);
      check("midop_rst_ovf",   32'(ext_ovf),   32'd0);
      hold(4'd3, 6);
      d0 = drops;
      capture("midop_after", 8'h03);
      check("midop_no_drop", 32'(drops - d0), 32'd0);

      // Reset during WAIT_STABLE aborts the in-flight capture.
      cnt_in = 4'd9;
      tick();
      req = 1'b1;
      tick();
      req = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      lat = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (out_valid) lat++;
      end
      check("wait_rst_no_valid", 32'(lat), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
